// File: rtl/axi_gran_split_txn_tracker.sv
// Multi-ID AXI burst tracker: slot table with per-ID oldest-first lookup, bulk decrement and error marking.
// Optional occupancy statistics are enabled with AXI_RT_SPLIT_TRACKER_STATS_EN.
module axi_gran_split_txn_tracker #(
    parameter int unsigned MaxTxns     = 8,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned LenWidth    = 8,
    parameter int unsigned CntIdxWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [IdWidth-1:0]     alloc_id_i,
    input  logic [LenWidth-1:0]    alloc_len_i,
    input  logic                   alloc_req_i,
    output logic                   alloc_gnt_o,
    input  logic [IdWidth-1:0]     cnt_id_i,
    input  logic                   cnt_req_i,
    output logic                   cnt_gnt_o,
    output logic [LenWidth-1:0]    cnt_len_o,
    input  logic                   cnt_dec_i,
    input  logic [LenWidth:0]      cnt_delta_i,
    input  logic                   cnt_set_err_i,
    output logic                   cnt_err_o,
    output logic                   cnt_last_o,
    output logic                   cnt_ovf_o,
    output logic [CntIdxWidth:0]   occ_o,
    output logic [CntIdxWidth:0]   occ_max_o
);

    localparam int unsigned RemWidth = LenWidth + 1;
    localparam int unsigned OccWidth = CntIdxWidth + 1;

    logic [MaxTxns-1:0]  valid_q, valid_d;
    logic [MaxTxns-1:0]  err_q, err_d;
    logic [IdWidth-1:0]  id_q  [MaxTxns];
    logic [IdWidth-1:0]  id_d  [MaxTxns];
    logic [RemWidth-1:0] rem_q [MaxTxns];
    logic [RemWidth-1:0] rem_d [MaxTxns];
    // older_q[i][j] set means slot i was allocated before slot j
    logic [MaxTxns-1:0]  older_q [MaxTxns];
    logic [MaxTxns-1:0]  older_d [MaxTxns];

    logic [CntIdxWidth-1:0] alloc_idx;
    logic                   alloc_found;
    logic                   alloc_fire;
    logic [MaxTxns-1:0]     match;
    logic [MaxTxns-1:0]     oldest;
    logic [CntIdxWidth-1:0] sel_idx;
    logic                   sel_found;
    logic [RemWidth-1:0]    sel_rem;
    logic                   sel_err;
    logic                   dec_fire;

    // Lowest-index free slot, from registered valid bits only
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = int'(MaxTxns) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx   = CntIdxWidth'(i);
                alloc_found = 1'b1;
            end
        end
    end

    assign alloc_gnt_o = !rst_i && !flush_i && alloc_found;
    assign alloc_fire  = alloc_req_i && alloc_gnt_o;

    // Oldest matching slot: a match that is older than every other match
    always_comb begin
        match  = '0;
        oldest = '0;
        for (int i = 0; i < int'(MaxTxns); i++) begin
            match[i] = valid_q[i] && (id_q[i] == cnt_id_i);
        end
        for (int i = 0; i < int'(MaxTxns); i++) begin
            oldest[i] = match[i];
            for (int j = 0; j < int'(MaxTxns); j++) begin
                if (j != i && match[j] && !older_q[i][j]) begin
                    oldest[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = int'(MaxTxns) - 1; i >= 0; i--) begin
            if (oldest[i]) begin
                sel_idx = CntIdxWidth'(i);
            end
        end
    end

    assign sel_found = |match;
    assign sel_rem   = rem_q[sel_idx];
    assign sel_err   = err_q[sel_idx];

    assign cnt_gnt_o  = !rst_i && cnt_req_i && sel_found;
    assign dec_fire   = cnt_gnt_o && cnt_dec_i && (cnt_delta_i != '0);
    assign cnt_last_o = dec_fire && (cnt_delta_i >= sel_rem);
    assign cnt_ovf_o  = cnt_gnt_o && cnt_dec_i && (cnt_delta_i > sel_rem);
    assign cnt_len_o  = cnt_gnt_o ? LenWidth'(sel_rem - RemWidth'(1)) : '0;
    assign cnt_err_o  = cnt_gnt_o && (sel_err || cnt_set_err_i);

    // Next table state; flush overrides every other update
    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        for (int i = 0; i < int'(MaxTxns); i++) begin
            id_d[i]    = id_q[i];
            rem_d[i]   = rem_q[i];
            older_d[i] = older_q[i];
        end
        if (flush_i) begin
            valid_d = '0;
            err_d   = '0;
            for (int i = 0; i < int'(MaxTxns); i++) begin
                rem_d[i] = '0;
            end
        end else begin
            if (cnt_gnt_o) begin
                if (cnt_set_err_i) begin
                    err_d[sel_idx] = 1'b1;
                end
                if (dec_fire) begin
                    if (cnt_last_o) begin
                        valid_d[sel_idx] = 1'b0;
                        rem_d[sel_idx]   = '0;
                    end else begin
                        rem_d[sel_idx] = sel_rem - cnt_delta_i;
                    end
                end
            end
            if (alloc_fire) begin
                valid_d[alloc_idx] = 1'b1;
                err_d[alloc_idx]   = 1'b0;
                id_d[alloc_idx]    = alloc_id_i;
                rem_d[alloc_idx]   = RemWidth'(alloc_len_i) + RemWidth'(1);
                older_d[alloc_idx] = '0;
                for (int j = 0; j < int'(MaxTxns); j++) begin
                    if (CntIdxWidth'(j) != alloc_idx) begin
                        older_d[j][alloc_idx] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < int'(MaxTxns); i++) begin
                id_q[i]    <= '0;
                rem_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < int'(MaxTxns); i++) begin
                id_q[i]    <= id_d[i];
                rem_q[i]   <= rem_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

`ifdef AXI_RT_SPLIT_TRACKER_STATS_EN
    logic [OccWidth-1:0] occ_q;
    logic [OccWidth-1:0] occ_max_q;

    // Occupancy follows allocations and completions; watermark lags occupancy by one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q     <= '0;
            occ_max_q <= '0;
        end else begin
            if (occ_q > occ_max_q) begin
                occ_max_q <= occ_q;
            end
            if (flush_i) begin
                occ_q <= '0;
            end else if (alloc_fire && !cnt_last_o) begin
                occ_q <= occ_q + OccWidth'(1);
            end else if (!alloc_fire && cnt_last_o) begin
                occ_q <= occ_q - OccWidth'(1);
            end
        end
    end

    assign occ_o     = occ_q;
    assign occ_max_o = occ_max_q;
`else
    assign occ_o     = '0;
    assign occ_max_o = '0;
`endif

endmodule
